// File: rtl/decrypt_out_packer.sv
// decrypt_out_packer: packs plaintext bytes into 32-bit little-endian words
// and buffers them in a small word FIFO drained over ready/valid. Words that
// arrive while the FIFO is full are dropped and flagged with a sticky bit.
module decrypt_out_packer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [7:0]    din,
  input  logic          flush,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [31:0]   out_data,
  output logic [2:0]    out_bytes,
  output logic [CW-1:0] level,
  output logic          overflow,
  input  logic          clr_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] LVL_FULL = CW'(DEPTH);

  logic [1:0]    cnt_q, cnt_d;
  logic [23:0]   hold_q, hold_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;

  logic [31:0]   mem_data_q  [DEPTH];
  logic [2:0]    mem_bytes_q [DEPTH];

  logic          push_req;
  logic [31:0]   push_data;
  logic [2:0]    push_bytes;
  logic [31:0]   word;
  logic          pop;
  logic          push_ok;

  // Packer: place the incoming byte in its lane, push on the 4th byte or flush
  always_comb begin
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    push_req   = 1'b0;
    push_data  = '0;
    push_bytes = '0;
    word       = {8'h00, hold_q};
    if (en) begin
      // Lanes above cnt are always zero because hold is cleared on every push.
      word[{cnt_q, 3'b000} +: 8] = din;
      if ((cnt_q == 2'd3) || flush) begin
        push_req   = 1'b1;
        push_data  = word;
        push_bytes = {1'b0, cnt_q} + 3'd1;
        cnt_d      = '0;
        hold_d     = '0;
      end else begin
        cnt_d  = cnt_q + 2'd1;
        hold_d = word[23:0];
      end
    end else if (flush && (cnt_q != 2'd0)) begin
      push_req   = 1'b1;
      push_data  = {8'h00, hold_q};
      push_bytes = {1'b0, cnt_q};
      cnt_d      = '0;
      hold_d     = '0;
    end
  end

  // FIFO control: pointers, occupancy and sticky overflow (set beats clear)
  always_comb begin
    pop      = (level_q != '0) && out_ready;
    push_ok  = push_req && ((level_q != LVL_FULL) || pop);
    wr_ptr_d = push_ok ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    level_d  = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + CW'(1);
      2'b01:   level_d = level_q - CW'(1);
      default: level_d = level_q;
    endcase
    overflow_d = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    if (push_req && !push_ok) overflow_d = 1'b1;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      hold_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data_q[wr_ptr_q]  <= push_data;
      mem_bytes_q[wr_ptr_q] <= push_bytes;
    end
  end

  // Outputs come only from registers and storage, forced to 0 when empty
  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_data_q[rd_ptr_q]  : '0;
  assign out_bytes = out_valid ? mem_bytes_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_decrypt_out_packer.sv
// Bench for decrypt_out_packer: a byte-list reference model predicts pushed
// words into a scoreboard queue; words are compared as the DUT pops them.
module tb_decrypt_out_packer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [7:0]    din;
  logic          flush;
  logic          out_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic [2:0]    out_bytes;
  logic [CW-1:0] level;
  logic          overflow;
  logic          clr_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [34:0] sb[$];
  logic [7:0]  mb[$];
  int          mlevel = 0;
  logic        mov    = 1'b0;

  decrypt_out_packer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_bytes(out_bytes), .level(level), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs at negedge, advance the model, move to posedge+1
  task automatic tick();
    logic        pop_m, push_m, acc;
    logic [31:0] w;
    logic [2:0]  nb;
    @(negedge clk);
    check("level", 32'(level), 32'(mlevel));
    check("valid", 32'(out_valid), 32'(mlevel != 0));
    check("overflow", 32'(overflow), 32'(mov));
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("sb_underrun", 32'd1, 32'd0);
      end else begin
        check("data", out_data, sb[0][34:3]);
        check("bytes", 32'(out_bytes), 32'(sb[0][2:0]));
        if (out_ready) void'(sb.pop_front());
      end
    end else begin
      check("empty_data", out_data, 32'd0);
    end
    pop_m  = out_ready && (mlevel > 0);
    push_m = 1'b0;
    w      = '0;
    nb     = '0;
    if (en) begin
      mb.push_back(din);
      if ((mb.size() == 4) || flush) push_m = 1'b1;
    end else if (flush && (mb.size() > 0)) begin
      push_m = 1'b1;
    end
    if (push_m) begin
      for (int i = 0; i < mb.size(); i++) w[i*8 +: 8] = mb[i];
      nb = 3'(mb.size());
      mb.delete();
    end
    acc = push_m && ((mlevel < DEPTH) || pop_m);
    if (acc) sb.push_back({w, nb});
    if (push_m && !acc) mov = 1'b1;
    else if (clr_overflow) mov = 1'b0;
    mlevel = mlevel + int'(acc) - int'(pop_m);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic e, input logic [7:0] d, input logic f);
    en = e; din = d; flush = f;
    tick();
  endtask

  task automatic send_word(input logic [7:0] base);
    for (int i = 0; i < 4; i++) cyc(1'b1, base + 8'(i), 1'b0);
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"}, out_data, 32'd0);
    check({tag, "_bytes"}, 32'(out_bytes), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; din = '0; flush = 1'b0;
    out_ready = 1'b0; clr_overflow = 1'b0;
    #2;
    check_zero_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Full word streamed straight through
    out_ready = 1'b1;
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    cyc(1'b1, 8'h44, 1'b0);
    drain(2);
    check("w1_const", 32'h44332211, {8'h44, 8'h33, 8'h22, 8'h11} & {32{out_ready}});

    // Partial word by flush, then a flush with nothing pending
    cyc(1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    drain(3);

    // Byte with flush at cnt=0, and at cnt=3
    cyc(1'b1, 8'hCC, 1'b1);
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    cyc(1'b1, 8'h03, 1'b0);
    cyc(1'b1, 8'hDD, 1'b1);
    drain(3);

    // Overflow: DEPTH+1 words with no consumer, drain, realign, clear
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) send_word(8'(8'h10 * (k + 1)));
    cyc(1'b0, 8'h00, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    drain(DEPTH + 2);
    send_word(8'hE0);
    drain(2);
    clr_overflow = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    clr_overflow = 1'b0;
    drain(1);
    check("ovf_clr", 32'(overflow), 32'd0);

    // Push into a full FIFO while it pops in the same cycle
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) send_word(8'(8'h20 + 8'(k * 4)));
    cyc(1'b1, 8'h51, 1'b0);
    cyc(1'b1, 8'h52, 1'b0);
    cyc(1'b1, 8'h53, 1'b0);
    out_ready = 1'b1;
    cyc(1'b1, 8'h54, 1'b0);
    check("full_pp_level", 32'(level), 32'(DEPTH));
    check("full_pp_ovf", 32'(overflow), 32'd0);
    drain(DEPTH + 2);

    // Pointer wrap over 3*DEPTH words with a randomly stalling consumer
    for (int k = 0; k < 3 * DEPTH; k++) begin
      for (int b = 0; b < 4; b++) begin
        out_ready = 1'($urandom_range(0, 1));
        cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      end
    end
    drain(DEPTH + 2);
    check("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-word with several words queued
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_word(8'(8'h60 + 8'(k * 4)));
    cyc(1'b1, 8'h71, 1'b0);
    cyc(1'b1, 8'h72, 1'b0);
    check("pre_rst_level", 32'(level), 32'd3);
    en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    sb.delete(); mb.delete(); mlevel = 0; mov = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    cyc(1'b1, 8'h03, 1'b0);
    cyc(1'b1, 8'h04, 1'b0);
    @(negedge clk);
    check("post_rst_word", out_data, 32'h04030201);
    @(posedge clk);
    #1;
    sb.delete(); mlevel = 0;
    drain(2);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decrypt_out_packer.md
# decrypt_out_packer

Output stage downstream of the decrypt pipeline. It collects the valid plaintext bytes (`v`/`dout`) into 32-bit little-endian words and buffers them in a small word FIFO. The FIFO drains over a ready/valid interface to the host-side consumer. The decrypt pipeline cannot stall, so the packer absorbs bursts and flags any word lost to a full FIFO with a sticky overflow bit.

## Interface

Parameters:
- `DEPTH`, default 4: number of FIFO word entries; power of two, ≥2.
- `CW`, default `$clog2(DEPTH+1)`: width of `level`.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `en` input 1: byte strobe; connects to decrypt pipeline `v`.
- `din` input 8: plaintext byte; connects to decrypt pipeline `dout`; sampled only when `en`=1.
- `flush` input 1: push the current partial word, if any, at the end of the message.
- `out_ready` input 1: consumer accepts the head word this cycle.
- `out_valid` output 1: FIFO non-empty; head word presented.
- `out_data` output 32: head word; byte0 (first received) in [7:0].
- `out_bytes` output 3: number of valid bytes in the head word, 1..4.
- `level` output CW: number of FIFO entries occupied, 0..DEPTH.
- `overflow` output 1: sticky; a word was dropped because the FIFO was full.
- `clr_overflow` input 1: synchronous clear of `overflow`.

## Operation

Packer:
- Holds a 2-bit byte counter `cnt` (0..3) and a 24-bit holding register.
- `en`=1 with `cnt`<3: store `din` in byte lane `cnt`; `cnt`++.
- `en`=1 with `cnt`=3: form the word `{din, hold[23:0]}` with `out_bytes`=4. Issue a push request and set `cnt`=0.
- `flush`=1 with `en`=0 and `cnt`>0: push `{zero-pad, hold}` with `out_bytes`=`cnt`. Set `cnt`=0.
- `flush`=1 with `en`=1:
  - The byte is appended first, then pushed.
  - The pushed word contains `cnt`+1 bytes.
  - If `cnt`=3, only one push occurs; it carries 4 bytes.
- `flush`=1 with `cnt`=0 and `en`=0: no operation; no empty word is pushed.
- Unused upper lanes of a partial word are 0.

FIFO:
- Storage is DEPTH entries of {data[31:0], bytes[2:0]}.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Occupancy is tracked by `level`.
- Pop occurs when `out_valid && out_ready`.
- Push is accepted when `level`<DEPTH, or when `level`=DEPTH and a pop occurs in the same cycle.
- On a simultaneous push and pop, `level` is unchanged.
- If a push is rejected:
  - The word is discarded.
  - `overflow` is set to 1 on the next edge.
  - The packer still clears `cnt`, so the byte alignment of later data is preserved.
- `overflow` clearing:
  - `clr_overflow` clears `overflow`.
  - If a set condition and `clr_overflow` occur in the same cycle, set wins.

Reset:
- Asserting `rst` at any time, including mid-word or mid-drain, asynchronously forces the following:
  - `cnt`=0, holding register = 0, pointers = 0.
  - `level`=0, `out_valid`=0, `out_data`=0, `out_bytes`=0, `overflow`=0.
- FIFO memory contents need not be reset.
- Outputs read 0 whenever `level`=0.

## Timing

- Push latency: the pushing edge is the 4th `en` byte at edge N, or a `flush` at edge N. With an empty FIFO, `out_valid`=1 and `out_data` are valid after edge N, i.e. in cycle N+1.
- `out_data`, `out_bytes` and `out_valid` are driven from registers and FIFO storage only, with no combinational path from `en`, `din` or `flush`.
- Handshake rules:
  - `out_data`/`out_bytes` hold stable while `out_valid`=1 and `out_ready`=0.
  - Once asserted, `out_valid` deasserts only after a pop.
- Sustained throughput:
  - The packer accepts `en` every cycle, giving 1 word per 4 cycles.
  - The FIFO accepts 1 push and 1 pop per cycle.
- `out_ready` does not depend on `out_valid`; a pop attempt with `out_valid`=0 has no effect.

## Test plan

- Bytes 0x11,0x22,0x33,0x44 on consecutive `en` cycles, `out_ready`=1 -> one cycle after the 4th byte: `out_valid`=1, `out_data`=0x44332211, `out_bytes`=4. The word pops in the same cycle and `level` returns to 0.
- Bytes 0xAA,0xBB, then `flush` alone -> `out_data`=0x0000BBAA, `out_bytes`=2. A second `flush` with `cnt`=0 pushes nothing.
- Byte 0xCC with `flush` in the same cycle at `cnt`=0 -> `out_data`=0x000000CC, `out_bytes`=1. Byte 0xDD with `flush` at `cnt`=3 -> a single 4-byte word.
- `out_ready`=0 with DEPTH+1 full words streamed:
  - `level` saturates at 4 and `overflow`=1 after the 5th push.
  - Draining returns exactly words 1..4 in order, and the next word packs aligned.
  - `clr_overflow` then clears `overflow`.
- `level`=DEPTH with `out_ready`=1 and a push in the same cycle -> push accepted, `level` stays at DEPTH, `overflow` stays 0. Pointer wrap is verified over 3×DEPTH words.
- `rst` asserted asynchronously mid-word (`cnt`=2) with `level`=3 -> all outputs go to 0 immediately. After release, bytes 0x01..0x04 produce 0x04030201.
